// File: rtl/pak_dsp_pkg.sv
// Shared types and helpers for the pak_dsp FFT stream sequencer.
package pak_dsp_pkg;

  localparam int FFT_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    COLLECT,
    WAIT,
    DRAIN
  } fft_ctrl_state_t;

  typedef struct packed {
    logic [30:0] bin;
    logic        isImag;
  } fft_sel_t;

  // Output words interleave real and imag per bin, so the low bit picks the part.
  function automatic fft_sel_t fft_out_sel(input logic [31:0] rdIdx);
    fft_sel_t sel;
    sel.bin    = rdIdx[31:1];
    sel.isImag = rdIdx[0];
    return sel;
  endfunction

endpackage

// File: rtl/fft_stream_ctrl.sv
// Frame sequencer around a parallel N-point FFT: deserialise samples, hold them
// for the FFT latency, capture the bins and stream them out real/imag per bin.
import pak_dsp_pkg::*;

module fft_stream_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int N           = FFT_N_DEFAULT,
  parameter int FFT_LATENCY = 0
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             flush,
  input  logic [DATA_WIDTH-1:0]            src_data_in,
  input  logic                             src_valid_in,
  output logic                             src_ready_out,
  output logic [N-1:0][DATA_WIDTH-1:0]     fft_x_real,
  output logic [N-1:0][DATA_WIDTH-1:0]     fft_x_imag,
  input  logic [N-1:0][DATA_WIDTH-1:0]     fft_X_real,
  input  logic [N-1:0][DATA_WIDTH-1:0]     fft_X_imag,
  output logic [DATA_WIDTH-1:0]            dst_data_out,
  output logic                             dst_valid_out,
  input  logic                             dst_ready_in,
  output logic                             dst_last_out,
  output logic                             busy
);

  localparam int WW = $clog2(N);
  localparam int RW = $clog2(2 * N);
  localparam int CW = (FFT_LATENCY > 0) ? $clog2(FFT_LATENCY + 1) : 1;

  localparam logic [WW-1:0] WR_LAST  = WW'(N - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(2 * N - 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(FFT_LATENCY);

  fft_ctrl_state_t                 r_state;
  logic [WW-1:0]                   r_wrIdx;
  logic [RW-1:0]                   r_rdIdx;
  logic [CW-1:0]                   r_cnt;
  logic [N-1:0][DATA_WIDTH-1:0]    r_bufReal;
  logic [N-1:0][DATA_WIDTH-1:0]    r_bufImag;
  fft_sel_t                        w_sel;
  logic [DATA_WIDTH-1:0]           w_word;

  assign fft_x_imag   = '0;
  assign busy         = (r_state != COLLECT);
  assign dst_last_out = dst_valid_out && (r_rdIdx == RD_LAST);
  assign dst_data_out = dst_valid_out ? w_word : '0;
  assign w_sel        = fft_out_sel(32'(r_rdIdx));

  always_comb begin
    w_word = '0;
    for (int k = 0; k < N; k++) begin
      if (w_sel.bin == 31'(k)) begin
        w_word = w_sel.isImag ? r_bufImag[k] : r_bufReal[k];
      end
    end
  end

  // Flush outranks any handshake in the same cycle, so that handshake is dropped.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state       <= COLLECT;
      r_wrIdx       <= '0;
      r_rdIdx       <= '0;
      r_cnt         <= '0;
      r_bufReal     <= '0;
      r_bufImag     <= '0;
      fft_x_real    <= '0;
      src_ready_out <= 1'b0;
      dst_valid_out <= 1'b0;
    end else if (flush) begin
      r_state       <= COLLECT;
      r_wrIdx       <= '0;
      r_rdIdx       <= '0;
      r_cnt         <= '0;
      src_ready_out <= 1'b1;
      dst_valid_out <= 1'b0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          src_ready_out <= 1'b1;
          if (src_valid_in && src_ready_out) begin
            fft_x_real[r_wrIdx] <= src_data_in;
            if (r_wrIdx == WR_LAST) begin
              r_wrIdx       <= '0;
              r_cnt         <= LAT_LOAD;
              r_state       <= WAIT;
              src_ready_out <= 1'b0;
            end else begin
              r_wrIdx <= r_wrIdx + 1'b1;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_bufReal     <= fft_X_real;
            r_bufImag     <= fft_X_imag;
            r_rdIdx       <= '0;
            r_state       <= DRAIN;
            dst_valid_out <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (dst_ready_in) begin
            if (r_rdIdx == RD_LAST) begin
              r_rdIdx       <= '0;
              r_state       <= COLLECT;
              dst_valid_out <= 1'b0;
              src_ready_out <= 1'b1;
            end else begin
              r_rdIdx <= r_rdIdx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Bench for fft_stream_ctrl: latency-2 and combinational FFT stubs, random frames
// compared against a frame-level model of the expected output word stream.
module tb_fft_stream_ctrl;

  localparam int DW  = 16;
  localparam int NP  = 8;
  localparam int LAT = 2;

  typedef logic [NP-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic arst, flush, srcValid, dstReady, useZero;
  logic [DW-1:0] srcData;

  logic aSrcReady, aDstValid, aDstLast, aBusy;
  logic [DW-1:0] aDstData;
  vec_t aXr, aXi, aFr, aFi, s1R, s1I;

  logic zSrcReady, zDstValid, zDstLast, zBusy;
  logic [DW-1:0] zDstData;
  vec_t zXr, zXi, zFr, zFi;

  logic mSrcReady, mDstValid, mDstLast, mBusy;
  logic [DW-1:0] mDstData;
  vec_t mXr, mXi;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frameVals[NP];
  logic [DW-1:0] expW[2*NP];
  int acceptNeg, fedCount, holdBreaks, firstValid, srcReadyBusy;
  logic [DW-1:0] gotWords[$];
  logic gotLast[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t stubRe(input vec_t x);
    vec_t r;
    for (int k = 0; k < NP; k++) r[k] = x[k] + DW'(k);
    return r;
  endfunction

  function automatic vec_t stubIm(input vec_t x);
    vec_t r;
    for (int k = 0; k < NP; k++) r[k] = -x[k];
    return r;
  endfunction

  always @(posedge clk) begin
    s1R <= stubRe(aXr);
    s1I <= stubIm(aXr);
    aFr <= s1R;
    aFi <= s1I;
  end

  assign zFr = stubRe(zXr);
  assign zFi = stubIm(zXr);

  assign mSrcReady = useZero ? zSrcReady : aSrcReady;
  assign mDstValid = useZero ? zDstValid : aDstValid;
  assign mDstLast  = useZero ? zDstLast  : aDstLast;
  assign mBusy     = useZero ? zBusy     : aBusy;
  assign mDstData  = useZero ? zDstData  : aDstData;
  assign mXr       = useZero ? zXr       : aXr;
  assign mXi       = useZero ? zXi       : aXi;

  fft_stream_ctrl #(.DATA_WIDTH(DW), .N(NP), .FFT_LATENCY(LAT)) dutA (
    .clk(clk), .arst(arst), .flush(flush),
    .src_data_in(srcData), .src_valid_in(srcValid), .src_ready_out(aSrcReady),
    .fft_x_real(aXr), .fft_x_imag(aXi), .fft_X_real(aFr), .fft_X_imag(aFi),
    .dst_data_out(aDstData), .dst_valid_out(aDstValid), .dst_ready_in(dstReady),
    .dst_last_out(aDstLast), .busy(aBusy)
  );

  fft_stream_ctrl #(.DATA_WIDTH(DW), .N(NP), .FFT_LATENCY(0)) dutZ (
    .clk(clk), .arst(arst), .flush(flush),
    .src_data_in(srcData), .src_valid_in(srcValid), .src_ready_out(zSrcReady),
    .fft_x_real(zXr), .fft_x_imag(zXi), .fft_X_real(zFr), .fft_X_imag(zFi),
    .dst_data_out(zDstData), .dst_valid_out(zDstValid), .dst_ready_in(dstReady),
    .dst_last_out(zDstLast), .busy(zBusy)
  );

  // Expected stream: bin k gives (x[k] + k) then (-x[k]), ascending bin.
  task automatic buildExpected;
    for (int k = 0; k < NP; k++) begin
      expW[2*k]   = DW'(frameVals[k] + k);
      expW[2*k+1] = DW'(-frameVals[k]);
    end
  endtask

  task automatic randomFrame;
    for (int k = 0; k < NP; k++) frameVals[k] = int'($urandom_range(65535));
    buildExpected();
  endtask

  task automatic feedFrame(input int nSamples, input int gapPct);
    int budget = 0;
    fedCount = 0;
    while (fedCount < nSamples && budget < 500) begin
      @(negedge clk);
      budget++;
      srcValid = (int'($urandom_range(99)) >= gapPct);
      srcData  = DW'(frameVals[fedCount]);
      if (srcValid && mSrcReady) begin
        fedCount++;
        acceptNeg = cyc;
      end
    end
  endtask

  task automatic drainFrame(input int maxWords, input int readyMode, input logic holdSrc);
    int budget = 0;
    int phase = 0;
    logic pend = 1'b0;
    logic [DW-1:0] pendWord = '0;
    gotWords.delete();
    gotLast.delete();
    holdBreaks = 0;
    firstValid = -1;
    srcReadyBusy = 0;
    while (gotWords.size() < maxWords && budget < 400) begin
      @(negedge clk);
      budget++;
      if (!holdSrc) srcValid = 1'b0;
      if (mBusy && mSrcReady) srcReadyBusy++;
      if (mDstValid && firstValid < 0) firstValid = cyc;
      if (pend && (!mDstValid || mDstData !== pendWord)) holdBreaks++;
      dstReady = (readyMode == 0) ? 1'b1 : ((phase % 3) == 0);
      if (mDstValid) phase++;
      if (mDstValid && dstReady) begin
        gotWords.push_back(mDstData);
        gotLast.push_back(mDstLast);
        pend = 1'b0;
      end else if (mDstValid) begin
        pend = 1'b1;
        pendWord = mDstData;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (mSrcReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b want 0", mSrcReady); end
    checks++; if (mDstValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", mDstValid); end
    checks++; if (mDstData !== '0) begin failures++; $display("[TB] FAIL reset_data: got %h want 0", mDstData); end
    checks++; if (mDstLast !== 1'b0) begin failures++; $display("[TB] FAIL reset_last: got %b want 0", mDstLast); end
    checks++; if (mBusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", mBusy); end
    checks++; if (mXr !== '0) begin failures++; $display("[TB] FAIL reset_xreal: got %h want 0", mXr); end
    checks++; if (mXi !== '0) begin failures++; $display("[TB] FAIL reset_ximag: got %h want 0", mXi); end
    arst = 1'b0;
    #1;
    checks++; if (mSrcReady !== 1'b0) begin failures++; $display("[TB] FAIL release_ready_early: got %b want 0", mSrcReady); end
    @(negedge clk);
    checks++; if (mSrcReady !== 1'b1) begin failures++; $display("[TB] FAIL release_ready: got %b want 1", mSrcReady); end
  endtask

  task automatic test_basic(input string tag, input int lat);
    for (int k = 0; k < NP; k++) frameVals[k] = 10 * (k + 1);
    buildExpected();
    feedFrame(NP, 0);
    checks++; if (fedCount !== NP) begin failures++; $display("[TB] FAIL %s_fed: got %0d want %0d", tag, fedCount, NP); end
    drainFrame(2 * NP, 0, 1'b0);
    checks++; if (gotWords.size() !== 2 * NP) begin failures++; $display("[TB] FAIL %s_count: got %0d want %0d", tag, gotWords.size(), 2 * NP); end
    for (int i = 0; i < gotWords.size(); i++) begin
      checks++; if (gotWords[i] !== expW[i]) begin failures++; $display("[TB] FAIL %s_word%0d: got %h want %h", tag, i, gotWords[i], expW[i]); end
      checks++; if (gotLast[i] !== (i == 2 * NP - 1)) begin failures++; $display("[TB] FAIL %s_last%0d: got %b want %b", tag, i, gotLast[i], (i == 2 * NP - 1)); end
    end
    checks++; if (firstValid - acceptNeg !== lat + 2) begin failures++; $display("[TB] FAIL %s_latency: got %0d want %0d", tag, firstValid - acceptNeg, lat + 2); end
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < NP; k++) frameVals[k] = 10 * (k + 1);
    buildExpected();
    feedFrame(NP, 0);
    drainFrame(2 * NP, 1, 1'b0);
    checks++; if (gotWords.size() !== 2 * NP) begin failures++; $display("[TB] FAIL bp_count: got %0d want %0d", gotWords.size(), 2 * NP); end
    for (int i = 0; i < gotWords.size(); i++) begin
      checks++; if (gotWords[i] !== expW[i]) begin failures++; $display("[TB] FAIL bp_word%0d: got %h want %h", i, gotWords[i], expW[i]); end
    end
    checks++; if (holdBreaks !== 0) begin failures++; $display("[TB] FAIL bp_hold: got %0d unstable words want 0", holdBreaks); end
  endtask

  task automatic test_input_gaps;
    logic [DW-1:0] ninth;
    ninth = DW'($urandom_range(65535));
    randomFrame();
    feedFrame(NP, 50);
    checks++; if (fedCount !== NP) begin failures++; $display("[TB] FAIL gap_fed: got %0d want %0d", fedCount, NP); end
    @(negedge clk);
    srcValid = 1'b1;
    srcData  = ninth;
    checks++; if (mSrcReady !== 1'b0) begin failures++; $display("[TB] FAIL gap_ready_wait: got %b want 0", mSrcReady); end
    drainFrame(2 * NP, 0, 1'b1);
    checks++; if (gotWords.size() !== 2 * NP) begin failures++; $display("[TB] FAIL gap_count: got %0d want %0d", gotWords.size(), 2 * NP); end
    for (int i = 0; i < gotWords.size(); i++) begin
      checks++; if (gotWords[i] !== expW[i]) begin failures++; $display("[TB] FAIL gap_word%0d: got %h want %h", i, gotWords[i], expW[i]); end
    end
    checks++; if (srcReadyBusy !== 0) begin failures++; $display("[TB] FAIL gap_ready_busy: got %0d cycles want 0", srcReadyBusy); end
    @(negedge clk);
    checks++; if (mSrcReady !== 1'b1) begin failures++; $display("[TB] FAIL gap_ready_back: got %b want 1", mSrcReady); end
    @(negedge clk);
    srcValid = 1'b0;
    checks++; if (mXr[0] !== ninth) begin failures++; $display("[TB] FAIL gap_ninth: got %h want %h", mXr[0], ninth); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_flush;
    vec_t held;
    randomFrame();
    for (int k = 0; k < NP; k++) held[k] = DW'(frameVals[k]);
    feedFrame(NP, 0);
    drainFrame(5, 0, 1'b0);
    checks++; if (gotWords.size() !== 5) begin failures++; $display("[TB] FAIL flush_pre_count: got %0d want 5", gotWords.size()); end
    for (int i = 0; i < gotWords.size(); i++) begin
      checks++; if (gotWords[i] !== expW[i]) begin failures++; $display("[TB] FAIL flush_pre_word%0d: got %h want %h", i, gotWords[i], expW[i]); end
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (mDstValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid: got %b want 0", mDstValid); end
    checks++; if (mSrcReady !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready: got %b want 1", mSrcReady); end
    checks++; if (mBusy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy: got %b want 0", mBusy); end
    checks++; if (mXr !== held) begin failures++; $display("[TB] FAIL flush_xkept: got %h want %h", mXr, held); end
    for (int k = 0; k < NP; k++) frameVals[k] = k + 1;
    buildExpected();
    feedFrame(NP, 0);
    drainFrame(2 * NP, 0, 1'b0);
    checks++; if (gotWords.size() !== 2 * NP) begin failures++; $display("[TB] FAIL flush_count: got %0d want %0d", gotWords.size(), 2 * NP); end
    for (int i = 0; i < gotWords.size(); i++) begin
      checks++; if (gotWords[i] !== expW[i]) begin failures++; $display("[TB] FAIL flush_word%0d: got %h want %h", i, gotWords[i], expW[i]); end
    end
  endtask

  task automatic test_arst_mid;
    randomFrame();
    feedFrame(3, 0);
    @(negedge clk);
    srcValid = 1'b0;
    #2 arst = 1'b1;
    #1;
    checks++; if (mSrcReady !== 1'b0) begin failures++; $display("[TB] FAIL arst_ready: got %b want 0", mSrcReady); end
    checks++; if (mXr !== '0) begin failures++; $display("[TB] FAIL arst_xreal: got %h want 0", mXr); end
    checks++; if (mBusy !== 1'b0 || mDstValid !== 1'b0) begin failures++; $display("[TB] FAIL arst_busy_valid: got %b%b want 00", mBusy, mDstValid); end
    @(negedge clk);
    arst = 1'b0;
    #1;
    checks++; if (mSrcReady !== 1'b0) begin failures++; $display("[TB] FAIL arst_ready_early: got %b want 0", mSrcReady); end
    @(negedge clk);
    checks++; if (mSrcReady !== 1'b1) begin failures++; $display("[TB] FAIL arst_ready_release: got %b want 1", mSrcReady); end
    randomFrame();
    feedFrame(NP, 0);
    drainFrame(2 * NP, 0, 1'b0);
    checks++; if (gotWords.size() !== 2 * NP) begin failures++; $display("[TB] FAIL arst_count: got %0d want %0d", gotWords.size(), 2 * NP); end
    for (int i = 0; i < gotWords.size(); i++) begin
      checks++; if (gotWords[i] !== expW[i]) begin failures++; $display("[TB] FAIL arst_word%0d: got %h want %h", i, gotWords[i], expW[i]); end
    end
  endtask

  task automatic test_latency0;
    @(negedge clk);
    arst = 1'b1;
    useZero = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    test_basic("lat0", 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    arst     = 1'b1;
    flush    = 1'b0;
    srcValid = 1'b0;
    srcData  = '0;
    dstReady = 1'b0;
    useZero  = 1'b0;
    test_reset();
    test_basic("basic", LAT);
    test_backpressure();
    test_input_gaps();
    test_flush();
    test_arst_mid();
    test_latency0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
